// File: rtl/redmule_mx_mc_fifo_if.sv
// rtl/redmule_mx_mc_fifo_if.sv - shared push/pop port bundle for the multi-channel MX FIFO
interface redmule_mx_mc_fifo_if #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned CH_W       = 1
);
  logic                  push_i;
  logic [CH_W-1:0]       push_ch_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  grant_o;
  logic                  pop_i;
  logic [CH_W-1:0]       pop_ch_i;
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] data_o;

  modport master (
    output push_i, push_ch_i, data_i, pop_i, pop_ch_i,
    input  grant_o, valid_o, data_o
  );

  modport slave (
    input  push_i, push_ch_i, data_i, pop_i, pop_ch_i,
    output grant_o, valid_o, data_o
  );
endinterface

// File: rtl/redmule_mx_mc_fifo.sv
// rtl/redmule_mx_mc_fifo.sv - multi-channel FWFT FIFO for MX streams, any depth >= 2
// Optional sticky overflow/underflow flags: define REDMULE_MX_FIFO_ERR_EN.
module redmule_mx_mc_fifo #(
  parameter  int unsigned DATA_WIDTH   = 256,
  parameter  int unsigned FIFO_DEPTH   = 8,
  parameter  int unsigned NUM_CHANNELS = 2,
  parameter  int unsigned AF_THRESH    = FIFO_DEPTH - 1,
  localparam int unsigned CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  redmule_mx_mc_fifo_if.slave                  fifo_bus,
  output logic [NUM_CHANNELS-1:0][CNT_W-1:0]   count_o,
  output logic [NUM_CHANNELS-1:0]              full_o,
  output logic [NUM_CHANNELS-1:0]              empty_o,
  output logic [NUM_CHANNELS-1:0]              almost_full_o
`ifdef REDMULE_MX_FIFO_ERR_EN
  ,
  output logic [NUM_CHANNELS-1:0]              err_ovf_o,
  output logic [NUM_CHANNELS-1:0]              err_udf_o
`endif
);

  localparam int unsigned    IDX_W = $clog2(FIFO_DEPTH);
  localparam logic [CH_W:0]  NCH   = (CH_W + 1)'(NUM_CHANNELS);

  logic [IDX_W-1:0]      r_rd_idx [NUM_CHANNELS];
  logic [IDX_W-1:0]      r_wr_idx [NUM_CHANNELS];
  logic [CNT_W-1:0]      r_count  [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] r_mem    [NUM_CHANNELS][FIFO_DEPTH];

  logic                    w_push_in_range;
  logic                    w_pop_in_range;
  logic [NUM_CHANNELS-1:0] w_full;
  logic [NUM_CHANNELS-1:0] w_empty;
  logic [NUM_CHANNELS-1:0] w_push_sel;
  logic [NUM_CHANNELS-1:0] w_pop_sel;
  logic [NUM_CHANNELS-1:0] w_push_fire;
  logic [NUM_CHANNELS-1:0] w_pop_fire;
  logic [DATA_WIDTH-1:0]   w_head;

  function automatic logic [IDX_W-1:0] f_next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(FIFO_DEPTH - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  // Out-of-range selects (non power-of-two channel counts) match no channel.
  assign w_push_in_range = {1'b0, fifo_bus.push_ch_i} < NCH;
  assign w_pop_in_range  = {1'b0, fifo_bus.pop_ch_i}  < NCH;

  always_comb begin
    w_full      = '0;
    w_empty     = '0;
    w_push_sel  = '0;
    w_pop_sel   = '0;
    w_push_fire = '0;
    w_pop_fire  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_full[c]      = (r_count[c] == CNT_W'(FIFO_DEPTH));
      w_empty[c]     = (r_count[c] == '0);
      w_push_sel[c]  = w_push_in_range && (fifo_bus.push_ch_i == CH_W'(c));
      w_pop_sel[c]   = w_pop_in_range && (fifo_bus.pop_ch_i == CH_W'(c));
      w_push_fire[c] = fifo_bus.push_i && w_push_sel[c] && !w_full[c];
      w_pop_fire[c]  = fifo_bus.pop_i && w_pop_sel[c] && !w_empty[c];
    end
  end

  always_comb begin
    w_head = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (w_pop_sel[c] && !w_empty[c]) begin
        w_head = r_mem[c][r_rd_idx[c]];
      end
    end
  end

  assign fifo_bus.grant_o = |(w_push_sel & ~w_full);
  assign fifo_bus.valid_o = |(w_pop_sel & ~w_empty);
  assign fifo_bus.data_o  = w_head;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_rd_idx[c] <= '0;
        r_wr_idx[c] <= '0;
        r_count[c]  <= '0;
      end
    end else if (clear_i) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_rd_idx[c] <= '0;
        r_wr_idx[c] <= '0;
        r_count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (w_push_fire[c]) begin
          r_wr_idx[c] <= f_next_idx(r_wr_idx[c]);
        end
        if (w_pop_fire[c]) begin
          r_rd_idx[c] <= f_next_idx(r_rd_idx[c]);
        end
        case ({w_push_fire[c], w_pop_fire[c]})
          2'b10:   r_count[c] <= r_count[c] + CNT_W'(1);
          2'b01:   r_count[c] <= r_count[c] - CNT_W'(1);
          default: r_count[c] <= r_count[c];
        endcase
      end
    end
  end

  // Storage carries no reset; stale words are unreachable once indices are zeroed.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (w_push_fire[c] && !clear_i) begin
        r_mem[c][r_wr_idx[c]] <= fifo_bus.data_i;
      end
    end
  end

  always_comb begin
    count_o       = '0;
    almost_full_o = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      count_o[c]       = r_count[c];
      almost_full_o[c] = (r_count[c] >= CNT_W'(AF_THRESH));
    end
  end

  assign full_o  = w_full;
  assign empty_o = w_empty;

`ifdef REDMULE_MX_FIFO_ERR_EN
  logic [NUM_CHANNELS-1:0] r_err_ovf;
  logic [NUM_CHANNELS-1:0] r_err_udf;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_ovf <= '0;
      r_err_udf <= '0;
    end else if (clear_i) begin
      r_err_ovf <= '0;
      r_err_udf <= '0;
    end else begin
      r_err_ovf <= r_err_ovf | (w_push_sel & w_full & {NUM_CHANNELS{fifo_bus.push_i}});
      r_err_udf <= r_err_udf | (w_pop_sel & w_empty & {NUM_CHANNELS{fifo_bus.pop_i}});
    end
  end

  assign err_ovf_o = r_err_ovf;
  assign err_udf_o = r_err_udf;
`endif

endmodule

// File: tb/tb_redmule_mx_mc_fifo.sv
// tb/tb_redmule_mx_mc_fifo.sv - randomized queue-model bench for the multi-channel MX FIFO
module tb_redmule_mx_mc_fifo;
  localparam int DW = 32, DEPTH = 5, NCH = 3, AF = 4, CHW = 2, CNTW = 3;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic clear_i;
  logic [NCH-1:0][CNTW-1:0] count_o;
  logic [NCH-1:0] full_o, empty_o, almost_full_o;
`ifdef REDMULE_MX_FIFO_ERR_EN
  logic [NCH-1:0] err_ovf_o, err_udf_o;
  bit m_ovf [NCH];
  bit m_udf [NCH];
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mq [NCH][$];

  redmule_mx_mc_fifo_if #(.DATA_WIDTH(DW), .CH_W(CHW)) bus ();

  redmule_mx_mc_fifo #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .NUM_CHANNELS(NCH), .AF_THRESH(AF)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .fifo_bus(bus),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .almost_full_o(almost_full_o)
`ifdef REDMULE_MX_FIFO_ERR_EN
    , .err_ovf_o(err_ovf_o), .err_udf_o(err_udf_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input logic push, input logic [CHW-1:0] pch, input logic [DW-1:0] d,
                       input logic pop, input logic [CHW-1:0] qch, input logic clr);
    bus.push_i = push; bus.push_ch_i = pch; bus.data_i = d;
    bus.pop_i = pop; bus.pop_ch_i = qch; clear_i = clr;
  endtask

  task automatic model_flush();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
`ifdef REDMULE_MX_FIFO_ERR_EN
      m_ovf[c] = 0; m_udf[c] = 0;
`endif
    end
  endtask

  // Decide what the current request means for a queue model, then apply it after the edge.
  task automatic tick();
    bit pf = 0, qf = 0, so = 0, su = 0;
    int pc = int'(bus.push_ch_i);
    int qc = int'(bus.pop_ch_i);
    logic [DW-1:0] pd = bus.data_i;
    bit clr = clear_i;
    if (bus.push_i && pc < NCH) begin
      if (mq[pc].size() < DEPTH) pf = 1; else so = 1;
    end
    if (bus.pop_i && qc < NCH) begin
      if (mq[qc].size() > 0) qf = 1; else su = 1;
    end
    @(posedge clk_i);
    #1;
    if (clr) model_flush();
    else begin
      if (qf) void'(mq[qc].pop_front());
      if (pf) mq[pc].push_back(pd);
`ifdef REDMULE_MX_FIFO_ERR_EN
      if (so) m_ovf[pc] = 1;
      if (su) m_udf[qc] = 1;
`else
      if (so || su) begin end
`endif
    end
  endtask

  task automatic test_reset();
    for (int p = 0; p < 4; p++) begin
      drive(0, CHW'(p), '0, 0, CHW'(p), 0);
      #1;
      checks++;
      if (bus.grant_o !== (p < NCH)) begin errors++; $display("FAIL reset_grant[%0d] got %b exp %b", p, bus.grant_o, p < NCH); end
      checks++;
      if (bus.valid_o !== 1'b0 || bus.data_o !== '0) begin errors++; $display("FAIL reset_valid_data[%0d] got %b/%h exp 0/0", p, bus.valid_o, bus.data_o); end
    end
    checks++;
    if (empty_o !== 3'b111 || full_o !== 3'b000 || almost_full_o !== 3'b000 || count_o !== '0) begin
      errors++; $display("FAIL reset_status got e=%b f=%b af=%b cnt=%h exp e=111 f=000 af=000 cnt=0", empty_o, full_o, almost_full_o, count_o);
    end
`ifdef REDMULE_MX_FIFO_ERR_EN
    checks++;
    if (err_ovf_o !== '0 || err_udf_o !== '0) begin errors++; $display("FAIL reset_err got %b/%b exp 0/0", err_ovf_o, err_udf_o); end
`endif
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] w;
    for (int i = 0; i < 5; i++) begin
      w = DW'(32'hA1 + i);
      drive(1, 2'd1, w, 0, 2'd0, 0);
      #1;
      checks++;
      if (bus.grant_o !== 1'b1) begin errors++; $display("FAIL fill_grant[%0d] got %b exp 1", i, bus.grant_o); end
      tick();
      checks++;
      if (almost_full_o[1] !== (i + 1 >= AF)) begin errors++; $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full_o[1], i + 1 >= AF); end
    end
    checks++;
    if (full_o[1] !== 1'b1 || count_o[1] !== 3'd5) begin errors++; $display("FAIL fill_full got f=%b cnt=%0d exp f=1 cnt=5", full_o[1], count_o[1]); end
    drive(1, 2'd1, 32'hA6, 0, 2'd0, 0);
    #1;
    checks++;
    if (bus.grant_o !== 1'b0) begin errors++; $display("FAIL sixth_grant got %b exp 0", bus.grant_o); end
    tick();
    checks++;
    if (count_o[1] !== 3'd5) begin errors++; $display("FAIL sixth_count got %0d exp 5", count_o[1]); end
    for (int i = 0; i < 5; i++) begin
      drive(0, 2'd0, '0, 1, 2'd1, 0);
      #1;
      checks++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== DW'(32'hA1 + i)) begin
        errors++; $display("FAIL drain_data[%0d] got %b/%h exp 1/%h", i, bus.valid_o, bus.data_o, 32'hA1 + i);
      end
      tick();
    end
    checks++;
    if (empty_o[1] !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty_o[1]); end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) begin
        drive(1, 2'd0, DW'($urandom), 0, 2'd0, 0);
        tick();
      end
      for (int i = 0; i < 3; i++) begin
        drive(0, 2'd0, '0, 1, 2'd0, 0);
        #1;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.data_o !== mq[0][0]) begin
          errors++; $display("FAIL wrap_data[%0d.%0d] got %b/%h exp 1/%h", r, i, bus.valid_o, bus.data_o, mq[0][0]);
        end
        tick();
      end
    end
    checks++;
    if (count_o[0] !== 3'd0) begin errors++; $display("FAIL wrap_count got %0d exp 0", count_o[0]); end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] w;
    for (int i = 0; i < 2; i++) begin drive(1, 2'd0, DW'($urandom), 0, 2'd0, 0); tick(); end
    w = DW'($urandom);
    drive(1, 2'd0, w, 1, 2'd0, 0);
    #1;
    checks++;
    if (bus.grant_o !== 1'b1 || bus.valid_o !== 1'b1 || bus.data_o !== mq[0][0]) begin
      errors++; $display("FAIL same_ch_ports got g=%b v=%b d=%h exp 1/1/%h", bus.grant_o, bus.valid_o, bus.data_o, mq[0][0]);
    end
    tick();
    checks++;
    if (count_o[0] !== 3'd2) begin errors++; $display("FAIL same_ch_count got %0d exp 2", count_o[0]); end
    drive(1, 2'd2, DW'($urandom), 1, 2'd0, 0);
    tick();
    checks++;
    if (count_o[0] !== 3'd1 || count_o[2] !== 3'd1) begin errors++; $display("FAIL cross_ch_count got %0d/%0d exp 1/1", count_o[0], count_o[2]); end
    checks++;
    if (mq[0][0] !== w) begin errors++; $display("FAIL same_ch_model_order got %h exp %h", mq[0][0], w); end
    for (int c = 0; c < NCH; c += 2) begin
      drive(0, 2'd0, '0, 1, CHW'(c), 0);
      #1;
      checks++;
      if (bus.data_o !== mq[c][0]) begin errors++; $display("FAIL same_drain[%0d] got %h exp %h", c, bus.data_o, mq[c][0]); end
      tick();
    end
  endtask

  task automatic test_full_corner();
    logic [DW-1:0] w;
    for (int i = 0; i < 5; i++) begin drive(1, 2'd2, DW'($urandom), 0, 2'd0, 0); tick(); end
    drive(1, 2'd2, 32'hDEADBEEF, 1, 2'd2, 0);
    #1;
    checks++;
    if (bus.grant_o !== 1'b0 || bus.valid_o !== 1'b1) begin errors++; $display("FAIL full_popush got g=%b v=%b exp 0/1", bus.grant_o, bus.valid_o); end
    tick();
    checks++;
    if (count_o[2] !== 3'd4) begin errors++; $display("FAIL full_popush_count got %0d exp 4", count_o[2]); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 2'd0, '0, 1, 2'd2, 0);
      #1;
      checks++;
      if (bus.data_o !== mq[2][0]) begin errors++; $display("FAIL full_drain[%0d] got %h exp %h", i, bus.data_o, mq[2][0]); end
      tick();
    end
    w = DW'($urandom);
    drive(1, 2'd1, w, 1, 2'd1, 0);
    #1;
    checks++;
    if (bus.valid_o !== 1'b0 || bus.data_o !== '0) begin errors++; $display("FAIL empty_popush got v=%b d=%h exp 0/0", bus.valid_o, bus.data_o); end
    tick();
    drive(0, 2'd0, '0, 0, 2'd1, 0);
    #1;
    checks++;
    if (count_o[1] !== 3'd1 || bus.valid_o !== 1'b1 || bus.data_o !== w) begin
      errors++; $display("FAIL empty_popush_next got c=%0d v=%b d=%h exp 1/1/%h", count_o[1], bus.valid_o, bus.data_o, w);
    end
    drive(0, 2'd0, '0, 1, 2'd1, 0);
    tick();
  endtask

  task automatic test_oor_clear();
    for (int i = 0; i < 4; i++) begin drive(1, (i < 3) ? 2'd0 : 2'd1, DW'($urandom), 0, 2'd0, 0); tick(); end
    drive(1, 2'd3, DW'($urandom), 1, 2'd3, 0);
    #1;
    checks++;
    if (bus.grant_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.data_o !== '0) begin
      errors++; $display("FAIL oor_ports got g=%b v=%b d=%h exp 0/0/0", bus.grant_o, bus.valid_o, bus.data_o);
    end
    tick();
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (count_o[c] !== CNTW'(mq[c].size())) begin errors++; $display("FAIL oor_count[%0d] got %0d exp %0d", c, count_o[c], mq[c].size()); end
    end
    drive(1, 2'd0, DW'($urandom), 1, 2'd0, 1);
    tick();
    drive(0, 2'd0, '0, 0, 2'd0, 0);
    #1;
    checks++;
    if (count_o !== '0 || bus.valid_o !== 1'b0 || bus.data_o !== '0) begin
      errors++; $display("FAIL clear got cnt=%h v=%b d=%h exp 0/0/0", count_o, bus.valid_o, bus.data_o);
    end
  endtask

`ifdef REDMULE_MX_FIFO_ERR_EN
  task automatic test_err();
    for (int i = 0; i < 6; i++) begin drive(1, 2'd0, DW'($urandom), 0, 2'd0, 0); tick(); end
    drive(0, 2'd0, '0, 0, 2'd0, 0);
    tick();
    checks++;
    if (err_ovf_o !== 3'b001) begin errors++; $display("FAIL err_ovf got %b exp 001", err_ovf_o); end
    drive(0, 2'd0, '0, 1, 2'd1, 0);
    tick();
    checks++;
    if (err_udf_o !== 3'b010 || err_ovf_o !== 3'b001) begin errors++; $display("FAIL err_udf got %b/%b exp 010/001", err_udf_o, err_ovf_o); end
    drive(0, 2'd0, '0, 1, 2'd1, 1);
    tick();
    checks++;
    if (err_udf_o !== '0 || err_ovf_o !== '0) begin errors++; $display("FAIL err_clear got %b/%b exp 0/0", err_udf_o, err_ovf_o); end
  endtask
`endif

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin drive(1, CHW'(i % 2), DW'($urandom), 0, 2'd0, 0); tick(); end
    drive(1, 2'd0, DW'($urandom), 1, 2'd0, 0);
    #2;
    rst_ni = 1'b0;
    model_flush();
    #1;
    checks++;
    if (count_o !== '0 || empty_o !== 3'b111 || full_o !== '0 || almost_full_o !== '0) begin
      errors++; $display("FAIL midrst_status got cnt=%h e=%b f=%b af=%b exp 0/111/0/0", count_o, empty_o, full_o, almost_full_o);
    end
    checks++;
    if (bus.valid_o !== 1'b0 || bus.data_o !== '0 || bus.grant_o !== 1'b1) begin
      errors++; $display("FAIL midrst_ports got v=%b d=%h g=%b exp 0/0/1", bus.valid_o, bus.data_o, bus.grant_o);
    end
`ifdef REDMULE_MX_FIFO_ERR_EN
    checks++;
    if (err_ovf_o !== '0 || err_udf_o !== '0) begin errors++; $display("FAIL midrst_err got %b/%b exp 0/0", err_ovf_o, err_udf_o); end
`endif
    drive(0, 2'd0, '0, 0, 2'd0, 0);
    #2;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_random();
    logic expg, expv;
    logic [DW-1:0] expd;
    int pc, qc;
    for (int n = 0; n < 400; n++) begin
      pc = int'($urandom_range(0, 3));
      qc = int'($urandom_range(0, 3));
      drive(1'($urandom_range(0, 1)), CHW'(pc), DW'($urandom), 1'($urandom_range(0, 2) == 0),
            CHW'(qc), 1'($urandom_range(0, 39) == 0));
      #1;
      expg = (pc < NCH) && (mq[pc].size() < DEPTH);
      expv = (qc < NCH) && (mq[qc].size() > 0);
      expd = expv ? mq[qc][0] : '0;
      checks++;
      if (bus.grant_o !== expg || bus.valid_o !== expv || bus.data_o !== expd) begin
        errors++; $display("FAIL rnd_ports[%0d] got %b/%b/%h exp %b/%b/%h", n, bus.grant_o, bus.valid_o, bus.data_o, expg, expv, expd);
      end
      tick();
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if (count_o[c] !== CNTW'(mq[c].size()) || full_o[c] !== (mq[c].size() == DEPTH) ||
            empty_o[c] !== (mq[c].size() == 0) || almost_full_o[c] !== (mq[c].size() >= AF)) begin
          errors++; $display("FAIL rnd_status[%0d][%0d] got c=%0d f=%b e=%b af=%b exp c=%0d", n, c, count_o[c], full_o[c], empty_o[c], almost_full_o[c], mq[c].size());
        end
`ifdef REDMULE_MX_FIFO_ERR_EN
        checks++;
        if (err_ovf_o[c] !== m_ovf[c] || err_udf_o[c] !== m_udf[c]) begin
          errors++; $display("FAIL rnd_err[%0d][%0d] got %b/%b exp %b/%b", n, c, err_ovf_o[c], err_udf_o[c], m_ovf[c], m_udf[c]);
        end
`endif
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(0, 2'd0, '0, 0, 2'd0, 0);
    model_flush();
    #12;
    test_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    test_fill_drain();
    test_wrap();
    test_same_cycle();
    test_full_corner();
    test_oor_clear();
`ifdef REDMULE_MX_FIFO_ERR_EN
    test_err();
`endif
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
